// File: rtl/spart_driver.sv
// rtl/spart_driver.sv - SPART bus master: programs the baud divisor from br_cfg, then echoes every received byte.
// Optional feature macro: SPART_DRV_BRCFG_TRACK_EN (reprogram the divisor when br_cfg changes while idle).
module spart_driver #(
    parameter logic [15:0] DB_4800  = 16'd650,
    parameter logic [15:0] DB_9600  = 16'd324,
    parameter logic [15:0] DB_19200 = 16'd161,
    parameter logic [15:0] DB_38400 = 16'd80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  br_cfg,
    input  logic        rda,
    input  logic        tbr,
    output logic        iocs,
    output logic        iorw,
    output logic [1:0]  ioaddr,
    inout  wire  [7:0]  databus,
    output logic [7:0]  last_char,
    output logic [15:0] char_count
);

    typedef enum logic [2:0] {
        CFG_LO   = 3'd0,
        CFG_HI   = 3'd1,
        IDLE     = 3'd2,
        READ     = 3'd3,
        WAIT_TBR = 3'd4,
        WRITE    = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  cfg_q;
    logic [15:0] div_sel;
    logic [7:0]  dout;
    logic        drive;

    function automatic logic [15:0] divisor(input logic [1:0] sel);
        case (sel)
            2'b00:   divisor = DB_4800;
            2'b01:   divisor = DB_9600;
            2'b10:   divisor = DB_19200;
            default: divisor = DB_38400;
        endcase
    endfunction

    // CFG_LO uses the live switches; every later cycle uses the value latched in CFG_LO.
    assign div_sel = divisor((state == CFG_LO) ? br_cfg : cfg_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CFG_LO;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q      <= 2'b00;
            last_char  <= 8'h00;
            char_count <= 16'h0000;
        end else begin
            if (state == CFG_LO) begin
                cfg_q <= br_cfg;
            end
            if (state == READ) begin
                last_char <= databus;
            end
            if (state == WRITE) begin
                char_count <= char_count + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CFG_LO:   state_nxt = CFG_HI;
            CFG_HI:   state_nxt = IDLE;
            IDLE: begin
`ifdef SPART_DRV_BRCFG_TRACK_EN
                if (br_cfg != cfg_q) begin
                    state_nxt = CFG_LO;
                end else if (rda) begin
                    state_nxt = READ;
                end
`else
                if (rda) begin
                    state_nxt = READ;
                end
`endif
            end
            READ:     state_nxt = WAIT_TBR;
            WAIT_TBR: if (tbr) state_nxt = WRITE;
            WRITE:    state_nxt = IDLE;
            default:  state_nxt = CFG_LO;
        endcase
    end

    // Outputs are held at their idle values while rst is high so the bus is quiet during reset.
    always_comb begin
        iocs   = 1'b0;
        iorw   = 1'b1;
        ioaddr = 2'b00;
        dout   = 8'h00;
        if (!rst) begin
            case (state)
                CFG_LO: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = 2'b10;
                    dout   = div_sel[7:0];
                end
                CFG_HI: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = 2'b11;
                    dout   = div_sel[15:8];
                end
                READ: begin
                    iocs   = 1'b1;
                end
                WRITE: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    dout   = last_char;
                end
                default: begin
                    iocs   = 1'b0;
                end
            endcase
        end
    end

    assign drive   = iocs & ~iorw;
    assign databus = drive ? dout : 8'hzz;

endmodule
